wb_arbiter: RTL and testbench

Round-robin arbiter that shares one Wishbone B4 pipelined slave port, normally the external memory/interconnect port, between N_MASTERS Wishbone masters such as per-core `l1_mau` instances or a debug/DMA master. A grant is held for a master's whole `cyc` cycle and is released only after every outstanding beat has been answered, so no response ever reaches the wrong master. The arbiter adds one cycle of grant latency and no data-path latency once a grant is held.

---
 rtl/wb_arbiter_pkg.sv | 23 ++
 rtl/wb_arbiter_rr_picker.sv | 30 +++
 rtl/wb_arbiter.sv | 150 +++++++++++++++
 tb/tb_wb_arbiter.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_arbiter_pkg.sv
// Shared definitions for wb_arbiter: core bus widths and arbiter FSM encodings.
// Optional response watchdog is enabled with the WB_ARB_TMO_EN macro.
`ifndef CORE_ADDR_WIDTH
`define CORE_ADDR_WIDTH 32
`endif
`ifndef CORE_DATA_WIDTH
`define CORE_DATA_WIDTH 32
`endif
`ifndef CORE_BE_WIDTH
`define CORE_BE_WIDTH 4
`endif

package wb_arbiter_pkg;
  typedef logic [1:0] arb_state_t;

  localparam logic [1:0] ARB_IDLE  = 2'd0;
  localparam logic [1:0] ARB_GRANT = 2'd1;
  localparam logic [1:0] ARB_DRAIN = 2'd2;

  function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction
endpackage

// File: rtl/wb_arbiter_rr_picker.sv
// Combinational round-robin picker: first requester at or after rr_ptr_i,
// searching upward with wrap-around.
module wb_arbiter_rr_picker #(
  parameter int N = 2,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] rr_ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] gnt_idx_o,
  output logic          any_o
);
  logic [IW-1:0] idx;

  // Walk offsets from farthest to nearest so the nearest requester wins.
  always_comb begin
    gnt_o     = '0;
    gnt_idx_o = '0;
    idx       = '0;
    any_o     = |req_i;
    for (int k = N - 1; k >= 0; k--) begin
      idx = IW'((int'(rr_ptr_i) + k) % N);
      if (req_i[idx]) begin
        gnt_o      = '0;
        gnt_o[idx] = 1'b1;
        gnt_idx_o  = idx;
      end
    end
  end
endmodule

// File: rtl/wb_arbiter.sv
// Round-robin Wishbone B4 pipelined arbiter; grant held for a whole cyc plus drain.
// Define WB_ARB_TMO_EN to build the response watchdog (TMO_CYCLES).
module wb_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter int N_MASTERS  = 2,
  parameter int MAX_OUTST  = 8,
  parameter int TMO_CYCLES = 255
) (
  input  logic                                  wb_clk_i,
  input  logic                                  wb_rst_n_i,
  input  logic [N_MASTERS-1:0]                  m_cyc_i,
  input  logic [N_MASTERS-1:0]                  m_stb_i,
  input  logic [N_MASTERS-1:0]                  m_we_i,
  input  logic [N_MASTERS*`CORE_ADDR_WIDTH-1:0] m_adr_i,
  input  logic [N_MASTERS*`CORE_DATA_WIDTH-1:0] m_dat_i,
  input  logic [N_MASTERS*`CORE_BE_WIDTH-1:0]   m_sel_i,
  output logic [`CORE_DATA_WIDTH-1:0]           m_dat_o,
  output logic [N_MASTERS-1:0]                  m_ack_o,
  output logic [N_MASTERS-1:0]                  m_err_o,
  output logic [N_MASTERS-1:0]                  m_stall_o,
  output logic                                  s_cyc_o,
  output logic                                  s_stb_o,
  output logic                                  s_we_o,
  output logic [`CORE_ADDR_WIDTH-1:0]           s_adr_o,
  output logic [`CORE_DATA_WIDTH-1:0]           s_dat_o,
  output logic [`CORE_BE_WIDTH-1:0]             s_sel_o,
  input  logic [`CORE_DATA_WIDTH-1:0]           s_dat_i,
  input  logic                                  s_ack_i,
  input  logic                                  s_err_i,
  input  logic                                  s_stall_i
);
  localparam int IW = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;
  localparam int OW = $clog2(MAX_OUTST + 1);
  localparam int AW = `CORE_ADDR_WIDTH;
  localparam int DW = `CORE_DATA_WIDTH;
  localparam int BW = `CORE_BE_WIDTH;

  if (N_MASTERS < 2 || N_MASTERS > 8 || MAX_OUTST < 1 || TMO_CYCLES < 1) begin : g_param_check
    $error("wb_arbiter: parameter out of range");
  end

  logic [1:0]           state_q, state_d;
  logic [IW-1:0]        gnt_idx_q, gnt_idx_d, rr_ptr_q, rr_ptr_d, pick_idx;
  logic [N_MASTERS-1:0] gnt_oh_q, gnt_oh_d, pick_oh;
  logic [OW-1:0]        outst_q, outst_d;
  logic                 pick_any, granted, busy, full, issue, resp, rel, tmo_hit;

  logic [AW-1:0] adr_arr [N_MASTERS];
  logic [DW-1:0] dat_arr [N_MASTERS];
  logic [BW-1:0] sel_arr [N_MASTERS];

  for (genvar gi = 0; gi < N_MASTERS; gi++) begin : g_slice
    assign adr_arr[gi] = m_adr_i[gi*AW +: AW];
    assign dat_arr[gi] = m_dat_i[gi*DW +: DW];
    assign sel_arr[gi] = m_sel_i[gi*BW +: BW];
  end

  wb_arbiter_rr_picker #(.N(N_MASTERS)) u_picker (
    .req_i     (m_cyc_i),
    .rr_ptr_i  (rr_ptr_q),
    .gnt_o     (pick_oh),
    .gnt_idx_o (pick_idx),
    .any_o     (pick_any)
  );

  assign granted = (state_q == ARB_GRANT);
  assign busy    = (state_q != ARB_IDLE);
  assign full    = (outst_q == OW'(MAX_OUTST));
  // Responses with nothing outstanding are stale and never forwarded.
  assign resp    = busy && (outst_q != '0) && (s_ack_i || s_err_i);

  assign s_cyc_o = busy;
  assign s_stb_o = granted && m_cyc_i[gnt_idx_q] && m_stb_i[gnt_idx_q] && !full;
  assign s_we_o  = granted && m_we_i[gnt_idx_q];
  assign s_adr_o = granted ? adr_arr[gnt_idx_q] : '0;
  assign s_dat_o = granted ? dat_arr[gnt_idx_q] : '0;
  assign s_sel_o = granted ? sel_arr[gnt_idx_q] : '0;
  assign issue   = s_stb_o && !s_stall_i;

  assign m_dat_o   = busy ? s_dat_i : '0;
  assign m_ack_o   = gnt_oh_q & {N_MASTERS{resp && s_ack_i}};
  assign m_err_o   = gnt_oh_q & {N_MASTERS{(resp && s_err_i) || tmo_hit}};
  assign m_stall_o = granted ? (~gnt_oh_q | {N_MASTERS{s_stall_i || full}}) : '1;

`ifdef WB_ARB_TMO_EN
  localparam int TW = $clog2(TMO_CYCLES + 1);
  logic [TW-1:0] tmo_q, tmo_d;
  logic          silent;

  assign silent  = busy && (outst_q != '0) && !s_ack_i && !s_err_i;
  assign tmo_hit = silent && (tmo_q == TW'(TMO_CYCLES - 1));
  assign tmo_d   = (silent && !tmo_hit) ? tmo_q + 1'b1 : '0;

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) tmo_q <= '0;
    else             tmo_q <= tmo_d;
  end
`else
  assign tmo_hit = 1'b0;
`endif

  always_comb begin
    outst_d = outst_q;
    if (issue && !resp)      outst_d = outst_q + 1'b1;
    else if (!issue && resp) outst_d = outst_q - 1'b1;
    if (tmo_hit)             outst_d = '0;
  end

  always_comb begin
    state_d   = state_q;
    gnt_idx_d = gnt_idx_q;
    gnt_oh_d  = gnt_oh_q;
    rr_ptr_d  = rr_ptr_q;
    rel       = 1'b0;
    case (state_q)
      ARB_IDLE: if (pick_any) begin
        state_d   = ARB_GRANT;
        gnt_idx_d = pick_idx;
        gnt_oh_d  = pick_oh;
      end
      ARB_GRANT: if (!m_cyc_i[gnt_idx_q]) begin
        if (outst_q == '0) rel = 1'b1;
        else               state_d = ARB_DRAIN;
      end
      ARB_DRAIN: if (outst_d == '0) rel = 1'b1;
      default: state_d = ARB_IDLE;
    endcase
    if (rel || tmo_hit) begin
      state_d  = ARB_IDLE;
      rr_ptr_d = IW'(rr_next(int'(gnt_idx_q), N_MASTERS));
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      state_q   <= ARB_IDLE;
      gnt_idx_q <= '0;
      gnt_oh_q  <= '0;
      rr_ptr_q  <= '0;
      outst_q   <= '0;
    end else begin
      state_q   <= state_d;
      gnt_idx_q <= gnt_idx_d;
      gnt_oh_q  <= gnt_oh_d;
      rr_ptr_q  <= rr_ptr_d;
      outst_q   <= outst_d;
    end
  end
endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter with 3 masters: vector table plus corner sequences.
module tb_wb_arbiter;
  localparam int N = 3;

  logic          clk, rst_n;
  logic [N-1:0]  m_cyc_i, m_stb_i, m_we_i;
  logic [N*32-1:0] m_adr_i, m_dat_i;
  logic [N*4-1:0]  m_sel_i;
  logic [31:0]   m_dat_o;
  logic [N-1:0]  m_ack_o, m_err_o, m_stall_o;
  logic          s_cyc_o, s_stb_o, s_we_o;
  logic [31:0]   s_adr_o, s_dat_o;
  logic [3:0]    s_sel_o;
  logic [31:0]   s_dat_i;
  logic          s_ack_i, s_err_i, s_stall_i;

  int n_checks = 0;
  int n_fail   = 0;

  wb_arbiter #(.N_MASTERS(N), .MAX_OUTST(8), .TMO_CYCLES(16)) dut (
    .wb_clk_i(clk), .wb_rst_n_i(rst_n),
    .m_cyc_i(m_cyc_i), .m_stb_i(m_stb_i), .m_we_i(m_we_i),
    .m_adr_i(m_adr_i), .m_dat_i(m_dat_i), .m_sel_i(m_sel_i),
    .m_dat_o(m_dat_o), .m_ack_o(m_ack_o), .m_err_o(m_err_o), .m_stall_o(m_stall_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o),
    .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o),
    .s_dat_i(s_dat_i), .s_ack_i(s_ack_i), .s_err_i(s_err_i), .s_stall_i(s_stall_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish in time");
    $fatal(1, "global timeout");
  end

  typedef struct {
    logic [2:0]  cyc, stb;
    logic [31:0] adr;
    logic        ack, stall;
    logic [31:0] sdat;
    logic        e_cyc, e_stb;
    logic [31:0] e_adr;
    logic [2:0]  e_ack, e_stall;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic [2:0] cyc, input logic [2:0] stb, input logic [31:0] adr,
                              input logic ack, input logic stall, input logic [31:0] sdat,
                              input logic e_cyc, input logic e_stb, input logic [31:0] e_adr,
                              input logic [2:0] e_ack, input logic [2:0] e_stall);
    vec_t v;
    v.cyc = cyc; v.stb = stb; v.adr = adr; v.ack = ack; v.stall = stall; v.sdat = sdat;
    v.e_cyc = e_cyc; v.e_stb = e_stb; v.e_adr = e_adr; v.e_ack = e_ack; v.e_stall = e_stall;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Master k sees address adr | k<<12 and write data 0xD000_000k.
  task automatic drive(input logic [2:0] cyc, input logic [2:0] stb, input logic [31:0] adr,
                       input logic ack, input logic stall, input logic [31:0] sdat);
    m_cyc_i = cyc;
    m_stb_i = stb;
    m_we_i  = '0;
    for (int k = 0; k < N; k++) begin
      m_adr_i[k*32 +: 32] = adr | (32'(k) << 12);
      m_dat_i[k*32 +: 32] = 32'hD000_0000 | 32'(k);
      m_sel_i[k*4 +: 4]   = 4'hF;
    end
    s_ack_i   = ack;
    s_stall_i = stall;
    s_dat_i   = sdat;
    s_err_i   = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    drive(3'b000, 3'b000, 32'h0, 1'b0, 1'b0, 32'h0);
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    // Contention from rr_ptr = 0
    vecs.push_back(mk(3'b011, 3'b000, 32'h200, 1'b0, 1'b0, 32'h00, 1'b0, 1'b0, 32'h0,    3'b000, 3'b111));
    vecs.push_back(mk(3'b011, 3'b001, 32'h200, 1'b0, 1'b0, 32'h00, 1'b1, 1'b1, 32'h200,  3'b000, 3'b110));
    vecs.push_back(mk(3'b011, 3'b000, 32'h200, 1'b1, 1'b0, 32'h55, 1'b1, 1'b0, 32'h200,  3'b001, 3'b110));
    vecs.push_back(mk(3'b010, 3'b000, 32'h200, 1'b0, 1'b0, 32'h00, 1'b1, 1'b0, 32'h200,  3'b000, 3'b110));
    vecs.push_back(mk(3'b011, 3'b000, 32'h200, 1'b0, 1'b0, 32'h00, 1'b0, 1'b0, 32'h0,    3'b000, 3'b111));
    vecs.push_back(mk(3'b011, 3'b010, 32'h200, 1'b0, 1'b0, 32'h00, 1'b1, 1'b1, 32'h1200, 3'b000, 3'b101));
    vecs.push_back(mk(3'b011, 3'b000, 32'h200, 1'b1, 1'b0, 32'h66, 1'b1, 1'b0, 32'h1200, 3'b010, 3'b101));
    vecs.push_back(mk(3'b001, 3'b000, 32'h200, 1'b0, 1'b0, 32'h00, 1'b1, 1'b0, 32'h1200, 3'b000, 3'b101));
    vecs.push_back(mk(3'b011, 3'b000, 32'h200, 1'b0, 1'b0, 32'h00, 1'b0, 1'b0, 32'h0,    3'b000, 3'b111));
    vecs.push_back(mk(3'b011, 3'b000, 32'h200, 1'b0, 1'b0, 32'h00, 1'b1, 1'b0, 32'h200,  3'b000, 3'b110));
    vecs.push_back(mk(3'b000, 3'b000, 32'h200, 1'b0, 1'b0, 32'h00, 1'b1, 1'b0, 32'h200,  3'b000, 3'b110));
    vecs.push_back(mk(3'b000, 3'b000, 32'h200, 1'b0, 1'b0, 32'h00, 1'b0, 1'b0, 32'h0,    3'b000, 3'b111));
    // Single master, 4 pipelined reads, one slave stall
    vecs.push_back(mk(3'b001, 3'b000, 32'h100, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0,   3'b000, 3'b111));
    vecs.push_back(mk(3'b001, 3'b001, 32'h100, 1'b0, 1'b1, 32'h0, 1'b1, 1'b1, 32'h100, 3'b000, 3'b111));
    vecs.push_back(mk(3'b001, 3'b001, 32'h100, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h100, 3'b000, 3'b110));
    vecs.push_back(mk(3'b001, 3'b001, 32'h104, 1'b1, 1'b0, 32'hA, 1'b1, 1'b1, 32'h104, 3'b001, 3'b110));
    vecs.push_back(mk(3'b001, 3'b001, 32'h108, 1'b1, 1'b0, 32'hB, 1'b1, 1'b1, 32'h108, 3'b001, 3'b110));
    vecs.push_back(mk(3'b001, 3'b001, 32'h10C, 1'b1, 1'b0, 32'hC, 1'b1, 1'b1, 32'h10C, 3'b001, 3'b110));
    vecs.push_back(mk(3'b001, 3'b000, 32'h10C, 1'b1, 1'b0, 32'hD, 1'b1, 1'b0, 32'h10C, 3'b001, 3'b110));
    vecs.push_back(mk(3'b000, 3'b000, 32'h10C, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h10C, 3'b000, 3'b110));
    vecs.push_back(mk(3'b000, 3'b000, 32'h10C, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0,   3'b000, 3'b111));
    // Pointer wrap through master 2; stray acks with nothing outstanding
    vecs.push_back(mk(3'b101, 3'b000, 32'h300, 1'b0, 1'b0, 32'h00, 1'b0, 1'b0, 32'h0,    3'b000, 3'b111));
    vecs.push_back(mk(3'b101, 3'b100, 32'h300, 1'b0, 1'b0, 32'h00, 1'b1, 1'b1, 32'h2300, 3'b000, 3'b011));
    vecs.push_back(mk(3'b101, 3'b000, 32'h300, 1'b1, 1'b0, 32'h77, 1'b1, 1'b0, 32'h2300, 3'b100, 3'b011));
    vecs.push_back(mk(3'b001, 3'b000, 32'h300, 1'b0, 1'b0, 32'h00, 1'b1, 1'b0, 32'h2300, 3'b000, 3'b011));
    vecs.push_back(mk(3'b001, 3'b000, 32'h300, 1'b1, 1'b0, 32'h88, 1'b0, 1'b0, 32'h0,    3'b000, 3'b111));
    vecs.push_back(mk(3'b001, 3'b000, 32'h300, 1'b1, 1'b0, 32'h99, 1'b1, 1'b0, 32'h300,  3'b000, 3'b110));
    vecs.push_back(mk(3'b000, 3'b000, 32'h300, 1'b0, 1'b0, 32'h00, 1'b1, 1'b0, 32'h300,  3'b000, 3'b110));
    vecs.push_back(mk(3'b000, 3'b000, 32'h300, 1'b0, 1'b0, 32'h00, 1'b0, 1'b0, 32'h0,    3'b000, 3'b111));

    // Reset values with live inputs
    rst_n = 1'b0;
    drive(3'b011, 3'b011, 32'h40, 1'b1, 1'b0, 32'hCAFE);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_s_cyc", 32'(s_cyc_o), 32'd0);
    chk("rst_s_stb", 32'(s_stb_o), 32'd0);
    chk("rst_s_adr", s_adr_o, 32'h0);
    chk("rst_m_stall", 32'(m_stall_o), 32'h7);
    chk("rst_m_ack", 32'(m_ack_o), 32'h0);
    chk("rst_m_dat", m_dat_o, 32'h0);
    drive(3'b000, 3'b000, 32'h0, 1'b0, 1'b0, 32'h0);
    rst_n = 1'b1;
    tick();

    foreach (vecs[i]) begin
      drive(vecs[i].cyc, vecs[i].stb, vecs[i].adr, vecs[i].ack, vecs[i].stall, vecs[i].sdat);
      #2;
      chk($sformatf("vec%0d_s_cyc", i), 32'(s_cyc_o), 32'(vecs[i].e_cyc));
      chk($sformatf("vec%0d_s_stb", i), 32'(s_stb_o), 32'(vecs[i].e_stb));
      chk($sformatf("vec%0d_s_adr", i), s_adr_o, vecs[i].e_adr);
      chk($sformatf("vec%0d_m_ack", i), 32'(m_ack_o), 32'(vecs[i].e_ack));
      chk($sformatf("vec%0d_m_stall", i), 32'(m_stall_o), 32'(vecs[i].e_stall));
      if (vecs[i].e_ack != 3'b000)
        chk($sformatf("vec%0d_m_dat", i), m_dat_o, vecs[i].sdat);
      tick();
    end

    // Drain: M0 drops cyc with 3 beats outstanding while M1 waits
    reset_dut();
    drive(3'b011, 3'b000, 32'h400, 1'b0, 1'b0, 32'h0);
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(3'b011, 3'b001, 32'h400 + 32'(4*i), 1'b0, 1'b0, 32'h0);
      tick();
    end
    drive(3'b010, 3'b000, 32'h40C, 1'b0, 1'b0, 32'h0);
    tick();
    for (int i = 0; i < 4; i++) begin
      drive(3'b010, 3'b000, 32'h40C, i > 0, 1'b0, 32'(i));
      #2;
      chk($sformatf("drain%0d_s_cyc", i), 32'(s_cyc_o), 32'd1);
      chk($sformatf("drain%0d_s_stb", i), 32'(s_stb_o), 32'd0);
      chk($sformatf("drain%0d_m1_stall", i), 32'(m_stall_o[1]), 32'd1);
      chk($sformatf("drain%0d_m_ack", i), 32'(m_ack_o), (i > 0) ? 32'd1 : 32'd0);
      tick();
    end
    drive(3'b010, 3'b000, 32'h40C, 1'b0, 1'b0, 32'h0);
    #2;
    chk("drain_idle_s_cyc", 32'(s_cyc_o), 32'd0);
    tick();
    #2;
    chk("drain_m1_grant_stall", 32'(m_stall_o), 32'h5);
    chk("drain_m1_grant_adr", s_adr_o, 32'h140C);
    chk("drain_m1_grant_dat", s_dat_o, 32'hD000_0001);
    chk("drain_m1_grant_sel", 32'(s_sel_o), 32'hF);
    tick();

    // Back-pressure: 8 beats fill the window, one ack frees one slot
    reset_dut();
    drive(3'b001, 3'b000, 32'h500, 1'b0, 1'b0, 32'h0);
    tick();
    for (int i = 0; i < 8; i++) begin
      drive(3'b001, 3'b001, 32'h500 + 32'(4*i), 1'b0, 1'b0, 32'h0);
      #2;
      chk($sformatf("bp%0d_stall", i), 32'(m_stall_o[0]), 32'd0);
      tick();
    end
    drive(3'b001, 3'b001, 32'h520, 1'b0, 1'b0, 32'h0);
    #2;
    chk("bp_full_stall", 32'(m_stall_o[0]), 32'd1);
    chk("bp_full_stb", 32'(s_stb_o), 32'd0);
    tick();
    drive(3'b001, 3'b001, 32'h520, 1'b1, 1'b0, 32'hE);
    #2;
    chk("bp_ack_stall", 32'(m_stall_o[0]), 32'd1);
    chk("bp_ack_m_ack", 32'(m_ack_o), 32'd1);
    tick();
    drive(3'b001, 3'b001, 32'h520, 1'b0, 1'b0, 32'h0);
    #2;
    chk("bp_slot_stall", 32'(m_stall_o[0]), 32'd0);
    chk("bp_slot_stb", 32'(s_stb_o), 32'd1);
    tick();
    #2;
    chk("bp_refull_stall", 32'(m_stall_o[0]), 32'd1);
    chk("bp_refull_stb", 32'(s_stb_o), 32'd0);

    // Reset mid-operation: M1 holds a grant with 2 outstanding and rr_ptr = 1
    reset_dut();
    drive(3'b001, 3'b000, 32'h600, 1'b0, 1'b0, 32'h0);
    tick();
    drive(3'b000, 3'b000, 32'h600, 1'b0, 1'b0, 32'h0);
    tick();
    tick();
    drive(3'b010, 3'b000, 32'h600, 1'b0, 1'b0, 32'h0);
    tick();
    drive(3'b010, 3'b010, 32'h600, 1'b0, 1'b0, 32'h0);
    tick();
    tick();
    drive(3'b011, 3'b011, 32'h600, 1'b1, 1'b0, 32'hBAD);
    #2;
    chk("mid_pre_s_cyc", 32'(s_cyc_o), 32'd1);
    chk("mid_pre_m_ack", 32'(m_ack_o), 32'h2);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_s_cyc", 32'(s_cyc_o), 32'd0);
    chk("mid_rst_s_stb", 32'(s_stb_o), 32'd0);
    chk("mid_rst_s_adr", s_adr_o, 32'h0);
    chk("mid_rst_m_stall", 32'(m_stall_o), 32'h7);
    chk("mid_rst_m_ack", 32'(m_ack_o), 32'h0);
    chk("mid_rst_m_dat", m_dat_o, 32'h0);
    rst_n = 1'b1;
    drive(3'b011, 3'b000, 32'h600, 1'b0, 1'b0, 32'h0);
    tick();
    #2;
    chk("mid_after_m_stall", 32'(m_stall_o), 32'h6);
    chk("mid_after_s_adr", s_adr_o, 32'h600);
    tick();

`ifdef WB_ARB_TMO_EN
    // Watchdog: one beat, slave silent for 16 cycles
    reset_dut();
    drive(3'b001, 3'b000, 32'h700, 1'b0, 1'b0, 32'h0);
    tick();
    drive(3'b001, 3'b001, 32'h700, 1'b0, 1'b0, 32'h0);
    tick();
    drive(3'b001, 3'b000, 32'h700, 1'b0, 1'b0, 32'h0);
    for (int k = 1; k < 16; k++) begin
      #2;
      chk($sformatf("tmo_quiet%0d_err", k), 32'(m_err_o), 32'd0);
      tick();
    end
    #2;
    chk("tmo_err_pulse", 32'(m_err_o), 32'd1);
    tick();
    drive(3'b001, 3'b000, 32'h700, 1'b1, 1'b0, 32'h0);
    #2;
    chk("tmo_idle_s_cyc", 32'(s_cyc_o), 32'd0);
    chk("tmo_late_ack", 32'(m_ack_o), 32'd0);
    chk("tmo_idle_err", 32'(m_err_o), 32'd0);
    tick();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
